sample_info_bram_arbiter: RTL and testbench

SAMPLE_INFO_BRAM_ARBITER -- requirements
Module: sample_info_bram_arbiter

---
 rtl/sample_info_bram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sample_info_bram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_info_bram_arbiter.sv
// Arbitrates one sample-info BRAM port between a fetcher that holds ownership
// for as long as it requests, and a host issuing single read/write accesses.
module sample_info_bram_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 128,
    parameter int RD_LATENCY   = 2,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fa_req,
    output logic              fa_gnt,
    input  logic [ADDR_W-1:0] fa_addr,
    input  logic              fa_we,
    input  logic [DATA_W-1:0] fa_wdata,
    output logic [DATA_W-1:0] fa_rdata,
    input  logic              hb_req,
    input  logic              hb_we,
    input  logic [ADDR_W-1:0] hb_addr,
    input  logic [DATA_W-1:0] hb_wdata,
    output logic              hb_gnt,
    output logic [DATA_W-1:0] hb_rdata,
    output logic              hb_rvalid,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              lock_timeout
);

    localparam int LCK_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RD_W  = $clog2(RD_LATENCY + 1);
    localparam logic [LCK_W-1:0] LOCK_MAX     = LCK_W'(LOCK_TIMEOUT);
    localparam logic [LCK_W-1:0] LOCK_FLAG_AT = LCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [RD_W-1:0]  RD_CYCLES    = RD_W'(RD_LATENCY);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH_OWN = 2'd1,
        HOST_ACC  = 2'd2,
        HOST_RD   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              last_fetch_r;
    logic [LCK_W-1:0]  lock_cnt_r, lock_cnt_s;
    logic              lock_timeout_r;
    logic              lock_set_s;
    logic [RD_W-1:0]   rd_cnt_r, rd_cnt_s;
    logic              capture_s;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [DATA_W-1:0] din_hold_r;
    logic [DATA_W-1:0] hb_rdata_r;
    logic              hb_rvalid_r;
    logic              bram_en_s, bram_we_s;
    logic [ADDR_W-1:0] bram_addr_s;
    logic [DATA_W-1:0] bram_din_s;

    // Next-state logic, lock counter and host read latency counter
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = lock_cnt_r;
        rd_cnt_s   = rd_cnt_r;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (fa_req && hb_req) begin
                    state_s = last_fetch_r ? HOST_ACC : FETCH_OWN;
                end else if (fa_req) begin
                    state_s = FETCH_OWN;
                end else if (hb_req) begin
                    state_s = HOST_ACC;
                end else begin
                    state_s = IDLE;
                end
                if (state_s == FETCH_OWN) begin
                    lock_cnt_s = '0;
                end else begin
                    lock_cnt_s = lock_cnt_r;
                end
            end
            FETCH_OWN: begin
                if (fa_req) begin
                    state_s = FETCH_OWN;
                    if (lock_cnt_r != LOCK_MAX) begin
                        lock_cnt_s = lock_cnt_r + LCK_W'(1);
                    end else begin
                        lock_cnt_s = lock_cnt_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            HOST_ACC: begin
                rd_cnt_s = RD_CYCLES;
                if (hb_we) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOST_RD;
                end
            end
            HOST_RD: begin
                // Capture on the cycle the BRAM presents the addressed word
                if (rd_cnt_r == RD_W'(1)) begin
                    capture_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    rd_cnt_s = rd_cnt_r - RD_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // The flag is raised so that it is visible during the LOCK_TIMEOUT-th ownership cycle
    assign lock_set_s = (state_s == FETCH_OWN) && (lock_cnt_s >= LOCK_FLAG_AT);

    // BRAM port mux; a released-but-not-yet-idle fetcher issues nothing
    always_comb begin
        bram_en_s   = 1'b0;
        bram_we_s   = 1'b0;
        bram_addr_s = addr_hold_r;
        bram_din_s  = din_hold_r;
        case (state_r)
            FETCH_OWN: begin
                if (fa_req) begin
                    bram_en_s   = 1'b1;
                    bram_we_s   = fa_we;
                    bram_addr_s = fa_addr;
                    bram_din_s  = fa_wdata;
                end else begin
                    bram_en_s = 1'b0;
                end
            end
            HOST_ACC: begin
                bram_en_s   = 1'b1;
                bram_we_s   = hb_we;
                bram_addr_s = hb_addr;
                bram_din_s  = hb_wdata;
            end
            default: begin
                bram_en_s = 1'b0;
            end
        endcase
    end

    // State, counters, ownership history and registered host outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            last_fetch_r   <= 1'b0;
            lock_cnt_r     <= '0;
            lock_timeout_r <= 1'b0;
            rd_cnt_r       <= '0;
            addr_hold_r    <= '0;
            din_hold_r     <= '0;
            hb_rdata_r     <= '0;
            hb_rvalid_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            lock_cnt_r  <= lock_cnt_s;
            rd_cnt_r    <= rd_cnt_s;
            hb_rvalid_r <= capture_s;
            if (lock_set_s) begin
                lock_timeout_r <= 1'b1;
            end
            if (state_r == IDLE && state_s == FETCH_OWN) begin
                last_fetch_r <= 1'b1;
            end else if (state_r == IDLE && state_s == HOST_ACC) begin
                last_fetch_r <= 1'b0;
            end
            if (bram_en_s) begin
                addr_hold_r <= bram_addr_s;
                din_hold_r  <= bram_din_s;
            end
            if (capture_s) begin
                hb_rdata_r <= bram_dout;
            end
        end
    end

    assign fa_gnt       = (state_r == FETCH_OWN) && fa_req;
    assign hb_gnt       = (state_r == HOST_ACC);
    assign fa_rdata     = bram_dout;
    assign hb_rdata     = hb_rdata_r;
    assign hb_rvalid    = hb_rvalid_r;
    assign lock_timeout = lock_timeout_r;
    assign bram_en      = bram_en_s;
    assign bram_we      = bram_we_s;
    assign bram_addr    = bram_addr_s;
    assign bram_din     = bram_din_s;

endmodule

// File: tb/tb_sample_info_bram_arbiter.sv
// Scoreboard bench for sample_info_bram_arbiter with a behavioural BRAM of RD_LATENCY cycles.
module tb_sample_info_bram_arbiter;

    localparam int AW = 6;
    localparam int DW = 128;
    localparam int L  = 2;
    localparam int LT = 16;

    localparam logic [DW-1:0] D_AA = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66AA;
    localparam logic [DW-1:0] D_7  = 128'h7777_0000_1111_2222_3333_4444_5555_7777;
    localparam logic [DW-1:0] D_3A = 128'h3A3A_3A3A_0000_0000_FFFF_FFFF_1234_5678;
    localparam logic [DW-1:0] D_3B = 128'h3B3B_3B3B_CAFE_F00D_DEAD_BEEF_8765_4321;
    localparam logic [DW-1:0] D_9  = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
    localparam logic [DW-1:0] D_DE = 128'hDEDE_DEDE_0102_0304_0506_0708_090A_0B0C;

    logic          clk, reset_n;
    logic          fa_req, fa_gnt, fa_we;
    logic [AW-1:0] fa_addr;
    logic [DW-1:0] fa_wdata, fa_rdata;
    logic          hb_req, hb_we, hb_gnt, hb_rvalid;
    logic [AW-1:0] hb_addr;
    logic [DW-1:0] hb_wdata, hb_rdata;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;
    logic          lock_timeout;

    sample_info_bram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .fa_req(fa_req), .fa_gnt(fa_gnt), .fa_addr(fa_addr), .fa_we(fa_we),
        .fa_wdata(fa_wdata), .fa_rdata(fa_rdata),
        .hb_req(hb_req), .hb_we(hb_we), .hb_addr(hb_addr), .hb_wdata(hb_wdata),
        .hb_gnt(hb_gnt), .hb_rdata(hb_rdata), .hb_rvalid(hb_rvalid),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .lock_timeout(lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: read-first, data appears L edges after the address edge
    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] pipe [0:L-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            pipe[0] <= mem[bram_addr];
        end
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_dout = pipe[L-1];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int errors = 0;
    int checks = 0;
    int rv_seen = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every read-data pulse is matched against the oldest expected read
    always @(negedge clk) begin
        if (reset_n && hb_rvalid) begin
            exp_t e;
            rv_seen++;
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_cycle", DW'(cyc), DW'(e.cyc));
                check("rvalid_data", hb_rdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fa_gnt"}, DW'(fa_gnt), 0);
        check({tag, "_hb_gnt"}, DW'(hb_gnt), 0);
        check({tag, "_hb_rvalid"}, DW'(hb_rvalid), 0);
        check({tag, "_bram_en"}, DW'(bram_en), 0);
        check({tag, "_bram_we"}, DW'(bram_we), 0);
        check({tag, "_lock_timeout"}, DW'(lock_timeout), 0);
        check({tag, "_bram_addr"}, DW'(bram_addr), 0);
        check({tag, "_bram_din"}, bram_din, 0);
        check({tag, "_hb_rdata"}, hb_rdata, 0);
    endtask

    task automatic host_set(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        hb_req = 1'b1; hb_we = we; hb_addr = addr; hb_wdata = data;
    endtask

    // Called in the hb_gnt cycle: checks the BRAM command, books the expectation, releases the request
    task automatic host_on_gnt();
        exp_t e;
        check("hacc_en", DW'(bram_en), 1);
        check("hacc_we", DW'(bram_we), DW'(hb_we));
        check("hacc_addr", DW'(bram_addr), DW'(hb_addr));
        if (hb_we) begin
            check("hacc_din", bram_din, hb_wdata);
            ref_mem[hb_addr] = hb_wdata;
        end else begin
            e.cyc  = cyc + L + 1;
            e.data = ref_mem[hb_addr];
            exp_q.push_back(e);
        end
        tick();
        hb_req = 1'b0;
        check("hgnt_pulse", DW'(hb_gnt), 0);
    endtask

    task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int exp_wait);
        int n;
        host_set(we, addr, data);
        n = 0;
        do begin
            tick();
            n++;
        end while (!hb_gnt && n < 20);
        check("hgnt_wait", DW'(n), DW'(exp_wait));
        if (hb_gnt) host_on_gnt();
        else hb_req = 1'b0;
    endtask

    task automatic fetch_check(input string tag);
        check({tag, "_fa_gnt"}, DW'(fa_gnt), 1);
        check({tag, "_hb_gnt"}, DW'(hb_gnt), 0);
        check({tag, "_en"}, DW'(bram_en), 1);
        check({tag, "_we"}, DW'(bram_we), DW'(fa_we));
        check({tag, "_addr"}, DW'(bram_addr), DW'(fa_addr));
        if (fa_we) begin
            check({tag, "_din"}, bram_din, fa_wdata);
            ref_mem[fa_addr] = fa_wdata;
        end
    endtask

    // Fetcher drops its request; host expected after one IDLE cycle
    task automatic release_to_host();
        fa_req = 1'b0;
        #1;
        check("rel_fa_gnt", DW'(fa_gnt), 0);
        check("rel_bram_en", DW'(bram_en), 0);
        check("rel_bram_we", DW'(bram_we), 0);
        tick();
        check("rel_idle_hgnt", DW'(hb_gnt), 0);
        tick();
        check("rel_hgnt", DW'(hb_gnt), 1);
        if (hb_gnt) host_on_gnt();
        else hb_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_before;
        reset_n = 1'b0;
        fa_req = 1'b0; fa_we = 1'b0; fa_addr = '0; fa_wdata = '0;
        hb_req = 1'b0; hb_we = 1'b0; hb_addr = '0; hb_wdata = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Host write then read-back; first edge after release already grants
        host_op(1'b1, 6'd5, D_AA, 1);
        host_op(1'b0, 6'd5, '0, 1);
        repeat (L + 1) tick();
        check("rd_drained", DW'(exp_q.size()), 0);
        repeat (3) tick();
        check("rdata_hold", hb_rdata, D_AA);

        // Reset pulse one cycle after a read grant discards the read
        host_set(1'b0, 6'd5, '0);
        tick();
        check("gnt_before_rst", DW'(hb_gnt), 1);
        hb_req = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        rv_before = rv_seen;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("no_rvalid_after_rst", DW'(rv_seen), DW'(rv_before));

        // Tie after reset: fetcher first, host after fetcher release plus IDLE
        fa_req = 1'b1; fa_we = 1'b1; fa_addr = 6'd7; fa_wdata = D_7;
        host_set(1'b0, 6'd5, '0);
        tick();
        fetch_check("tie_f1");
        tick();
        fetch_check("tie_f2");
        tick();
        release_to_host();
        repeat (L + 1) tick();

        // Fetcher writes addr 3 twice while a host read of addr 3 waits
        fa_req = 1'b1; fa_we = 1'b1; fa_addr = 6'd3; fa_wdata = D_3A;
        tick();
        fetch_check("f3a");
        host_set(1'b0, 6'd3, '0);
        fa_wdata = D_3B;
        #1;
        fetch_check("f3b");
        tick();
        release_to_host();
        repeat (L + 1) tick();

        // Tie with fetcher served last: host wins, fetcher follows on next IDLE
        fa_req = 1'b1; fa_we = 1'b1; fa_addr = 6'd9; fa_wdata = D_9;
        tick();
        fetch_check("f9");
        fa_req = 1'b0;
        #1;
        check("f9_drop_gnt", DW'(fa_gnt), 0);
        tick();
        fa_req = 1'b1; fa_we = 1'b0; fa_addr = 6'd9;
        host_set(1'b1, 6'd9, D_DE);
        tick();
        check("tie2_hgnt", DW'(hb_gnt), 1);
        check("tie2_fa_wait", DW'(fa_gnt), 0);
        if (hb_gnt) host_on_gnt();
        else hb_req = 1'b0;
        tick();
        fetch_check("tie2_f");
        repeat (L) tick();
        check("fa_rdata_serial", fa_rdata, D_DE);
        fa_req = 1'b0;
        repeat (2) tick();

        // Lock timeout: flag during 16th ownership cycle, sticky afterwards
        check("lock_pre", DW'(lock_timeout), 0);
        fa_req = 1'b1; fa_we = 1'b0; fa_addr = 6'd0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("lock_cyc%0d", i), DW'(lock_timeout), DW'(i >= LT));
        end
        check("lock_own_kept", DW'(fa_gnt), 1);
        fa_req = 1'b0;
        repeat (2) tick();
        check("lock_sticky", DW'(lock_timeout), 1);
        check("lock_released", DW'(fa_gnt), 0);

        repeat (4) tick();
        check("final_drained", DW'(exp_q.size()), 0);
        check("rdata_final", hb_rdata, D_3B);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
